// File: rtl/branch_ctrl.sv
// Sequencing controller for the shared branch comparator: latches a branch,
// drives the comparator, resolves direction and handles mispredict redirect/flush.
module branch_ctrl #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_funct3,
    input  logic [XLEN-1:0]  req_rs1,
    input  logic [XLEN-1:0]  req_rs2,
    input  logic [XLEN-1:0]  req_pc,
    input  logic [XLEN-1:0]  req_imm,
    input  logic             req_pred_taken,
    input  logic             kill,
    output logic [XLEN-1:0]  cmp_rs1,
    output logic [XLEN-1:0]  cmp_rs2,
    output logic             cmp_brun,
    input  logic             cmp_breq,
    input  logic             cmp_brlt,
    output logic             res_valid,
    output logic             res_taken,
    output logic             res_illegal,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             flush,
    output logic [CNT_W-1:0] mispredict_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        CMP,
        RESOLVE,
        FLUSH
    } state_t;

    localparam logic [3:0]       FLUSH_EXTRA = 4'(FLUSH_CYCLES - 1);
    localparam bit               HAS_FLUSH   = (FLUSH_CYCLES > 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [XLEN-1:0]  PC_STEP     = XLEN'(4);

    state_t          state;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] imm_q;
    logic [XLEN-1:0] target_q;
    logic [2:0]      funct3_q;
    logic            pred_q;
    logic            taken_q;
    logic            illegal_q;
    logic            mispred_q;
    logic [3:0]      flush_left;

    logic            taken_c;
    logic            illegal_c;
    logic            resolve_ok;

    always_comb begin
        taken_c   = 1'b0;
        illegal_c = 1'b0;
        case (funct3_q)
            3'b000:         taken_c   = cmp_breq;
            3'b001:         taken_c   = ~cmp_breq;
            3'b100, 3'b110: taken_c   = cmp_brlt;
            3'b101, 3'b111: taken_c   = ~cmp_brlt;
            default:        illegal_c = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cmp_rs1        <= '0;
            cmp_rs2        <= '0;
            cmp_brun       <= 1'b0;
            pc_q           <= '0;
            imm_q          <= '0;
            target_q       <= '0;
            funct3_q       <= '0;
            pred_q         <= 1'b0;
            taken_q        <= 1'b0;
            illegal_q      <= 1'b0;
            mispred_q      <= 1'b0;
            flush_left     <= '0;
            mispredict_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && !kill) begin
                        cmp_rs1  <= req_rs1;
                        cmp_rs2  <= req_rs2;
                        cmp_brun <= (req_funct3[2:1] == 2'b11);
                        pc_q     <= req_pc;
                        imm_q    <= req_imm;
                        funct3_q <= req_funct3;
                        pred_q   <= req_pred_taken;
                        state    <= CMP;
                    end
                end
                CMP: begin
                    if (kill) begin
                        state <= IDLE;
                    end else begin
                        // Everything RESOLVE needs is captured here so its outputs
                        // depend only on registered data (plus kill gating).
                        taken_q   <= taken_c;
                        illegal_q <= illegal_c;
                        mispred_q <= ~illegal_c & (taken_c != pred_q);
                        target_q  <= taken_c ? (pc_q + imm_q) : (pc_q + PC_STEP);
                        state     <= RESOLVE;
                    end
                end
                RESOLVE: begin
                    state <= IDLE;
                    if (!kill && mispred_q) begin
                        if (mispredict_cnt != CNT_MAX) begin
                            mispredict_cnt <= mispredict_cnt + 1'b1;
                        end
                        if (HAS_FLUSH) begin
                            state      <= FLUSH;
                            flush_left <= FLUSH_EXTRA;
                        end
                    end
                end
                FLUSH: begin
                    if (kill || flush_left <= 4'd1) begin
                        state      <= IDLE;
                        flush_left <= '0;
                    end else begin
                        flush_left <= flush_left - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign resolve_ok     = (state == RESOLVE) & ~kill;
    assign req_ready      = (state == IDLE) & ~kill;
    assign res_valid      = resolve_ok;
    assign res_taken      = resolve_ok & taken_q;
    assign res_illegal    = resolve_ok & illegal_q;
    assign redirect_valid = resolve_ok & mispred_q;
    assign redirect_pc    = redirect_valid ? target_q : '0;
    assign flush          = redirect_valid | (state == FLUSH);

endmodule

// File: tb/tb_branch_ctrl.sv
// Bench for branch_ctrl: directed vectors, randomized branches against a
// behavioural model, kill/reset corner sequences and counter saturation.
module tb_branch_ctrl;

    localparam int XLEN = 32;
    localparam int FC   = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req_valid = 1'b0;
    logic [2:0]      req_funct3 = '0;
    logic [XLEN-1:0] req_rs1 = '0, req_rs2 = '0, req_pc = '0, req_imm = '0;
    logic            req_pred_taken = 1'b0;
    logic            kill = 1'b0;

    logic            ready_a, brun_a, breq_a, brlt_a, rv_a, rt_a, ri_a, redir_a, flush_a;
    logic [XLEN-1:0] crs1_a, crs2_a, rpc_a;
    logic [15:0]     cnt_a;

    logic            ready_s, brun_s, breq_s, brlt_s, rv_s, rt_s, ri_s, redir_s, flush_s;
    logic [XLEN-1:0] crs1_s, crs2_s, rpc_s;
    logic [3:0]      cnt_s;

    int passed = 0;
    int total  = 0;
    int cnt_m  = 0;
    logic [XLEN-1:0] last_rs1 = '0;

    always #5 clk = ~clk;

    // Behavioural comparator for each instance
    assign breq_a = (crs1_a == crs2_a);
    assign brlt_a = brun_a ? (crs1_a < crs2_a) : ($signed(crs1_a) < $signed(crs2_a));
    assign breq_s = (crs1_s == crs2_s);
    assign brlt_s = brun_s ? (crs1_s < crs2_s) : ($signed(crs1_s) < $signed(crs2_s));

    branch_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(FC), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready_a),
        .req_funct3(req_funct3), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_pc(req_pc),
        .req_imm(req_imm), .req_pred_taken(req_pred_taken), .kill(kill),
        .cmp_rs1(crs1_a), .cmp_rs2(crs2_a), .cmp_brun(brun_a), .cmp_breq(breq_a),
        .cmp_brlt(brlt_a), .res_valid(rv_a), .res_taken(rt_a), .res_illegal(ri_a),
        .redirect_valid(redir_a), .redirect_pc(rpc_a), .flush(flush_a), .mispredict_cnt(cnt_a)
    );

    branch_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(FC), .CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready_s),
        .req_funct3(req_funct3), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_pc(req_pc),
        .req_imm(req_imm), .req_pred_taken(req_pred_taken), .kill(kill),
        .cmp_rs1(crs1_s), .cmp_rs2(crs2_s), .cmp_brun(brun_s), .cmp_breq(breq_s),
        .cmp_brlt(brlt_s), .res_valid(rv_s), .res_taken(rt_s), .res_illegal(ri_s),
        .redirect_valid(redir_s), .redirect_pc(rpc_s), .flush(flush_s), .mispredict_cnt(cnt_s)
    );

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] rs1, rs2, pc, imm;
        logic        pred;
        logic        taken, illegal, misp, brun;
        logic [31:0] rpc;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    function automatic int sat4(input int c);
        return (c > 15) ? 15 : c;
    endfunction

    // Reference model: branch semantics straight from the ISA rules
    task automatic model(input logic [2:0] f3, input logic [31:0] rs1, rs2, pc, imm,
                         input logic pred, output logic taken, illegal, misp, brun,
                         output logic [31:0] rpc);
        taken   = 1'b0;
        illegal = (f3 == 3'd2) || (f3 == 3'd3);
        case (f3)
            3'd0: taken = (rs1 == rs2);
            3'd1: taken = (rs1 != rs2);
            3'd4: taken = ($signed(rs1) <  $signed(rs2));
            3'd5: taken = ($signed(rs1) >= $signed(rs2));
            3'd6: taken = (rs1 <  rs2);
            3'd7: taken = (rs1 >= rs2);
            default: taken = 1'b0;
        endcase
        brun = (f3 == 3'd6) || (f3 == 3'd7);
        misp = !illegal && (taken != pred);
        rpc  = taken ? pc + imm : pc + 32'd4;
    endtask

    // Presents a request and returns just after the handshake edge (first CMP sample)
    task automatic issue(input logic [2:0] f3, input logic [31:0] rs1, rs2, pc, imm,
                         input logic pred);
        int w = 0;
        @(negedge clk);
        req_funct3 = f3; req_rs1 = rs1; req_rs2 = rs2; req_pc = pc; req_imm = imm;
        req_pred_taken = pred; req_valid = 1'b1;
        #1;
        while (!ready_a && w < 20) begin
            @(negedge clk); #1; w++;
        end
        chk("issue_ready_timeout", (w < 20), 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        last_rs1  = rs1;
        #1;
    endtask

    task automatic exec_and_check(input string tag, input logic [2:0] f3,
                                  input logic [31:0] rs1, rs2, pc, imm, input logic pred,
                                  input logic e_taken, e_ill, e_misp, e_brun,
                                  input logic [31:0] e_rpc);
        int rv_first = 0, rv_cnt = 0, flush_n = 0, ready_at = 0, bad = 0;
        logic taken = 0, ill = 0, redir = 0, brun = 0;
        logic [31:0] rpc = '0, s1 = '0, s2 = '0;
        issue(f3, rs1, rs2, pc, imm, pred);
        for (int n = 1; n <= 6; n++) begin
            if (n == 1) begin brun = brun_a; s1 = crs1_a; s2 = crs2_a; end
            if (rv_a) begin
                rv_cnt++;
                if (rv_first == 0) rv_first = n;
                taken = rt_a; ill = ri_a;
            end else if (rt_a || ri_a) bad++;
            if (redir_a) begin
                redir = 1'b1; rpc = rpc_a;
                if (!rv_a) bad++;
            end else if (rpc_a != '0) bad++;
            if (flush_a) flush_n++;
            if (ready_a && ready_at == 0) ready_at = n;
            if (n < 6) begin @(negedge clk); #1; end
        end
        if (e_misp) cnt_m++;
        chk({tag, ".rv_cycle"}, rv_first, 2);
        chk({tag, ".rv_count"}, rv_cnt, 1);
        chk({tag, ".taken"}, taken, e_taken);
        chk({tag, ".illegal"}, ill, e_ill);
        chk({tag, ".redirect"}, redir, e_misp);
        chk({tag, ".redirect_pc"}, rpc, e_misp ? e_rpc : 32'h0);
        chk({tag, ".flush_cycles"}, flush_n, e_misp ? FC : 0);
        chk({tag, ".ready_at"}, ready_at, e_misp ? 2 + FC : 3);
        chk({tag, ".brun"}, brun, e_brun);
        chk({tag, ".cmp_rs1"}, s1, rs1);
        chk({tag, ".cmp_rs2"}, s2, rs2);
        chk({tag, ".cnt"}, cnt_a, cnt_m);
        chk({tag, ".cnt4"}, cnt_s, sat4(cnt_m));
        chk({tag, ".strobe_quiet"}, bad, 0);
    endtask

    task automatic quiet_cycles(input string tag, input int n);
        int seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk); #1;
            if (rv_a || redir_a || flush_a) seen++;
        end
        chk({tag, ".quiet"}, seen, 0);
    endtask

    initial begin
        logic t, il, m, b;
        logic [31:0] r, a1, a2, p, im;
        logic [2:0] f;
        logic pr;

        vecs[0] = '{3'd0, 32'h5, 32'h5, 32'h100, 32'h20, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[1] = '{3'd4, 32'hFFFFFFFF, 32'h1, 32'h200, 32'h40, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h240};
        vecs[2] = '{3'd6, 32'hFFFFFFFF, 32'h1, 32'h200, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
        vecs[3] = '{3'd1, 32'h1, 32'h2, 32'h300, 32'h8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[4] = '{3'd5, 32'h1, 32'h2, 32'hFFFFFFFC, 32'h80, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[5] = '{3'd0, 32'h7, 32'h7, 32'hFFFFFFF0, 32'h20, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h10};
        vecs[6] = '{3'd2, 32'h3, 32'h3, 32'h400, 32'h10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[7] = '{3'd3, 32'h3, 32'h4, 32'h500, 32'h10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[8] = '{3'd7, 32'h80000000, 32'h1, 32'h1000, 32'hFFFFFFF0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hFF0};
        vecs[9] = '{3'd5, 32'h80000000, 32'h1, 32'h2000, 32'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};

        #3;
        chk("reset.req_ready", ready_a, 1'b1);
        chk("reset.outputs", {rv_a, rt_a, ri_a, redir_a, flush_a, brun_a}, 6'b0);
        chk("reset.cmp_rs1", crs1_a, 32'h0);
        chk("reset.redirect_pc", rpc_a, 32'h0);
        chk("reset.cnt", cnt_a, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++)
            exec_and_check($sformatf("vec%0d", i), vecs[i].f3, vecs[i].rs1, vecs[i].rs2,
                           vecs[i].pc, vecs[i].imm, vecs[i].pred, vecs[i].taken,
                           vecs[i].illegal, vecs[i].misp, vecs[i].brun, vecs[i].rpc);

        for (int i = 0; i < 40; i++) begin
            f  = 3'($urandom_range(0, 7));
            a1 = $urandom;
            a2 = ($urandom_range(0, 3) == 0) ? a1 : $urandom;
            p  = $urandom & 32'hFFFFFFFC;
            im = $urandom;
            pr = 1'($urandom_range(0, 1));
            model(f, a1, a2, p, im, pr, t, il, m, b, r);
            exec_and_check($sformatf("rnd%0d", i), f, a1, a2, p, im, pr, t, il, m, b, r);
        end

        // kill during CMP
        issue(3'd0, 32'h9, 32'h9, 32'h600, 32'h40, 1'b0);
        kill = 1'b1; #1;
        chk("kill_cmp.ready_low", ready_a, 1'b0);
        @(negedge clk); kill = 1'b0; #1;
        chk("kill_cmp.ready_back", ready_a, 1'b1);
        chk("kill_cmp.no_result", rv_a, 1'b0);
        quiet_cycles("kill_cmp", 3);
        chk("kill_cmp.cnt", cnt_a, cnt_m);

        // kill during RESOLVE
        issue(3'd0, 32'h9, 32'h9, 32'h600, 32'h40, 1'b0);
        @(negedge clk); kill = 1'b1; #1;
        chk("kill_res.strobes", {rv_a, rt_a, redir_a, flush_a}, 4'b0);
        chk("kill_res.redirect_pc", rpc_a, 32'h0);
        @(negedge clk); kill = 1'b0; #1;
        chk("kill_res.ready", ready_a, 1'b1);
        chk("kill_res.flush", flush_a, 1'b0);
        chk("kill_res.cnt", cnt_a, cnt_m);

        // kill during first FLUSH cycle
        issue(3'd0, 32'h9, 32'h9, 32'h600, 32'h40, 1'b0);
        cnt_m++;
        @(negedge clk); #1;
        chk("kill_fl.resolve_flush", flush_a, 1'b1);
        @(negedge clk); kill = 1'b1; #1;
        chk("kill_fl.flush_held", flush_a, 1'b1);
        @(negedge clk); kill = 1'b0; #1;
        chk("kill_fl.flush_dropped", flush_a, 1'b0);
        chk("kill_fl.ready", ready_a, 1'b1);
        chk("kill_fl.cnt", cnt_a, cnt_m);

        // kill with a valid request in IDLE
        @(negedge clk);
        req_funct3 = 3'd0; req_rs1 = 32'hDEAD; req_rs2 = 32'hDEAD; req_valid = 1'b1; kill = 1'b1;
        #1;
        chk("kill_idle.ready", ready_a, 1'b0);
        @(negedge clk); @(negedge clk);
        req_valid = 1'b0; kill = 1'b0; #1;
        chk("kill_idle.not_latched", crs1_a, last_rs1);
        quiet_cycles("kill_idle", 3);

        // asynchronous reset in the middle of FLUSH
        issue(3'd0, 32'h9, 32'h9, 32'h600, 32'h40, 1'b0);
        @(negedge clk); @(negedge clk); #1;
        chk("rst_fl.in_flush", flush_a, 1'b1);
        #1 rst_n = 1'b0; #1;
        chk("rst_fl.outputs", {rv_a, rt_a, ri_a, redir_a, flush_a, brun_a}, 6'b0);
        chk("rst_fl.req_ready", ready_a, 1'b1);
        chk("rst_fl.cmp_rs1", crs1_a, 32'h0);
        chk("rst_fl.cnt", cnt_a, 16'h0);
        chk("rst_fl.cnt4", cnt_s, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt_m = 0;
        last_rs1 = '0;

        // saturation of the narrow counter
        for (int i = 0; i < 17; i++)
            exec_and_check($sformatf("sat%0d", i), 3'd1, 32'h1, 32'h2, 32'h800, 32'h100,
                           1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h900);
        chk("sat.cnt4_full", cnt_s, 4'hF);
        chk("sat.cnt16", cnt_a, 16'd17);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
